// File: rtl/imm_nibble_encoder.sv
// Serialises a 16-bit constant into the shortest run of 4-bit immediates, MSB nibble first.
// Consumer sign- or zero-extends the first nibble (out_mode) and shifts in the rest.
module imm_nibble_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_nibble,
    output logic        out_mode,
    output logic        out_first,
    output logic        out_last,
    output logic [2:0]  out_count,
    output logic [15:0] words_done
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e      state_q, state_d;
    logic [15:0] val_q, val_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        mode_q, mode_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] done_q, done_d;

    logic [4:1]  sfit, ufit;
    logic [1:0]  enc_idx;
    logic [2:0]  enc_n;
    logic        enc_mode;
    logic        out_hs, accept;

    function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] r;
        unique case (idx)
            2'd0:    r = v[3:0];
            2'd1:    r = v[7:4];
            2'd2:    r = v[11:8];
            default: r = v[15:12];
        endcase
        return r;
    endfunction

    // Signed fit at N: bits [15:4N-1] all equal. Unsigned fit at N: bits [15:4N] all zero.
    assign sfit[1] = (&in_value[15:3])  | ~(|in_value[15:3]);
    assign sfit[2] = (&in_value[15:7])  | ~(|in_value[15:7]);
    assign sfit[3] = (&in_value[15:11]) | ~(|in_value[15:11]);
    assign sfit[4] = 1'b1;
    assign ufit[1] = ~(|in_value[15:4]);
    assign ufit[2] = ~(|in_value[15:8]);
    assign ufit[3] = ~(|in_value[15:12]);
    assign ufit[4] = 1'b1;

    always_comb begin
        enc_idx  = 2'd3;
        enc_n    = 3'd4;
        enc_mode = 1'b0;
        if (sfit[1] | ufit[1]) begin
            enc_idx  = 2'd0;
            enc_n    = 3'd1;
            enc_mode = ~sfit[1];
        end else if (sfit[2] | ufit[2]) begin
            enc_idx  = 2'd1;
            enc_n    = 3'd2;
            enc_mode = ~sfit[2];
        end else if (sfit[3] | ufit[3]) begin
            enc_idx  = 2'd2;
            enc_n    = 3'd3;
            enc_mode = ~sfit[3];
        end
    end

    assign out_hs   = (state_q == StEmit) & out_ready;
    // Accepting on the last-nibble handshake avoids a bubble between words.
    assign in_ready = (state_q == StIdle) | (out_hs & last_q);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        idx_d    = idx_q;
        nibble_d = nibble_q;
        mode_d   = mode_q;
        first_d  = first_q;
        last_d   = last_q;
        count_d  = count_q;
        done_d   = done_q;

        if (out_hs && last_q) begin
            done_d = done_q + 16'd1;
        end

        if (accept) begin
            state_d  = StEmit;
            val_d    = in_value;
            idx_d    = enc_idx;
            nibble_d = nib_sel(in_value, enc_idx);
            mode_d   = enc_mode;
            first_d  = 1'b1;
            last_d   = (enc_idx == 2'd0);
            count_d  = enc_n;
        end else if (out_hs) begin
            if (last_q) begin
                state_d = StIdle;
            end else begin
                idx_d    = idx_q - 2'd1;
                nibble_d = nib_sel(val_q, idx_q - 2'd1);
                first_d  = 1'b0;
                last_d   = (idx_q == 2'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            val_q    <= 16'd0;
            idx_q    <= 2'd0;
            nibble_q <= 4'd0;
            mode_q   <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            count_q  <= 3'd0;
            done_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            idx_q    <= idx_d;
            nibble_q <= nibble_d;
            mode_q   <= mode_d;
            first_q  <= first_d;
            last_q   <= last_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign out_valid  = (state_q == StEmit);
    assign out_nibble = nibble_q;
    assign out_mode   = mode_q;
    assign out_first  = first_q;
    assign out_last   = last_q;
    assign out_count  = count_q;
    assign words_done = done_q;

endmodule

// File: tb/tb_imm_nibble_encoder.sv
// Directed vector table plus hand-written backpressure/back-to-back/reset sequences and a
// random stream checked by rebuilding each word the way the consumer does.
module tb_imm_nibble_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_nibble;
    logic        out_mode;
    logic        out_first;
    logic        out_last;
    logic [2:0]  out_count;
    logic [15:0] words_done;

    imm_nibble_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_mode   (out_mode),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_count  (out_count),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        int          n;
        logic        mode;
        logic [15:0] seq;   // expected nibbles, left-aligned, in emission order
    } vec_t;

    vec_t        vecs[11];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_done = 0;

    logic [15:0] bp_seq;
    bit          bp_ready[7];
    int          bp_k;

    logic [15:0] q[$];
    logic [15:0] cur, acc, exp_val, r16;
    logic [31:0] rnd;
    bit          have;
    int          cyc, sent, rcvd, nibs, en;
    logic        em;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Minimal N found by trying to rebuild v from its low 4N bits with each extension.
    task automatic model(input logic [15:0] v, output int n, output logic m);
        logic [15:0] mask, lo, sx;
        n = 4;
        m = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            mask = 16'hFFFF >> (16 - 4 * i);
            lo   = v & mask;
            sx   = v[4*i-1] ? (lo | ~mask) : lo;
            if (sx == v) begin
                n = i;
                m = 1'b0;
            end else if (lo == v) begin
                n = i;
                m = 1'b1;
            end
        end
    endtask

    task automatic run_word(input vec_t v);
        @(negedge clk);
        in_value  = v.value;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            check("valid", 32'(out_valid), 32'd1);
            check("nibble", 32'(out_nibble), 32'(v.seq[15-4*k -: 4]));
            check("mode", 32'(out_mode), 32'(v.mode));
            check("first", 32'(out_first), 32'(k == 0));
            check("last", 32'(out_last), 32'(k == v.n - 1));
            check("count", 32'(out_count), 32'(v.n));
            @(negedge clk);
        end
        exp_done++;
        check("idle_after_word", 32'(out_valid), 32'd0);
        check("words_done", 32'(words_done), 32'(exp_done[15:0]));
    endtask

    initial begin
        vecs[0]  = '{16'h0007, 1, 1'b0, 16'h7000};
        vecs[1]  = '{16'hFFF8, 1, 1'b0, 16'h8000};
        vecs[2]  = '{16'h0008, 1, 1'b1, 16'h8000};
        vecs[3]  = '{16'h00F0, 2, 1'b1, 16'hF000};
        vecs[4]  = '{16'hFF7F, 3, 1'b0, 16'hF7F0};
        vecs[5]  = '{16'h1234, 4, 1'b0, 16'h1234};
        vecs[6]  = '{16'h8000, 4, 1'b0, 16'h8000};
        vecs[7]  = '{16'hFFFF, 1, 1'b0, 16'hF000};
        vecs[8]  = '{16'h0080, 2, 1'b1, 16'h8000};
        vecs[9]  = '{16'hFF80, 2, 1'b0, 16'h8000};
        vecs[10] = '{16'hF800, 3, 1'b0, 16'h8000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 16'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_nibble", 32'(out_nibble), 32'd0);
        check("rst_out_mode", 32'(out_mode), 32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_words_done", 32'(words_done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_word(vecs[i]);

        // Backpressure: ready pattern 1,0,0,1,0,1,1 over nibbles of 0x1234.
        bp_seq   = 16'h1234;
        bp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp_k     = 0;
        @(negedge clk);
        in_value  = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = bp_ready[c];
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_nibble", 32'(out_nibble), 32'(bp_seq[15-4*bp_k -: 4]));
            check("bp_first", 32'(out_first), 32'(bp_k == 0));
            check("bp_last", 32'(out_last), 32'(bp_k == 3));
            check("bp_words_done_held", 32'(words_done), 32'(exp_done[15:0]));
            if (bp_ready[c]) bp_k++;
            @(negedge clk);
        end
        exp_done++;
        check("bp_idle", 32'(out_valid), 32'd0);
        check("bp_words_done", 32'(words_done), 32'(exp_done[15:0]));

        // Back-to-back: 0x0007 then 0x00F0 with no bubble.
        @(negedge clk);
        in_value  = 16'h0007;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_value = 16'h00F0;
        #1;
        check("b2b_nib0", 32'(out_nibble), 32'h7);
        check("b2b_last0", 32'({out_first, out_last}), 32'b11);
        check("b2b_in_ready_on_last", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid1", 32'(out_valid), 32'd1);
        check("b2b_nib1", 32'(out_nibble), 32'hF);
        check("b2b_flags1", 32'({out_first, out_last, out_mode}), 32'b101);
        check("b2b_count1", 32'(out_count), 32'd2);
        @(negedge clk);
        check("b2b_nib2", 32'(out_nibble), 32'h0);
        check("b2b_flags2", 32'({out_first, out_last}), 32'b01);
        @(negedge clk);
        exp_done += 2;
        check("b2b_idle", 32'(out_valid), 32'd0);
        check("b2b_words_done", 32'(words_done), 32'(exp_done[15:0]));

        // Reset in the middle of 0x1234.
        @(negedge clk);
        in_value  = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_nib1", 32'(out_nibble), 32'h1);
        @(negedge clk);
        check("mid_nib2", 32'(out_nibble), 32'h2);
        reset = 1'b1;
        #1;
        exp_done = 0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_words_done", 32'(words_done), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_no_more_nibbles", 32'(out_valid), 32'd0);
        run_word(vecs[1]);

        // Random stream, consumer-side rebuild.
        have = 1'b0;
        cyc  = 0;
        sent = 0;
        rcvd = 0;
        nibs = 0;
        acc  = 16'd0;
        cur  = 16'd0;
        while (rcvd < 10000 && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < 10000) begin
                rnd = $urandom;
                case ($urandom_range(3))
                    0:       r16 = rnd[15:0];
                    1:       r16 = {{12{rnd[3]}}, rnd[3:0]};
                    2:       r16 = {8'h00, rnd[7:0]};
                    default: r16 = {{4{rnd[11]}}, rnd[11:0]};
                endcase
                cur  = r16;
                have = 1'b1;
            end
            in_valid  = have;
            in_value  = cur;
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (out_first) begin
                    acc  = out_mode ? {12'h000, out_nibble} : {{12{out_nibble[3]}}, out_nibble};
                    nibs = 1;
                end else begin
                    acc  = {acc[11:0], out_nibble};
                    nibs++;
                end
                if (out_last) begin
                    if (q.size() == 0) begin
                        check("rnd_unexpected_word", 32'(acc), 32'hFFFF_FFFF);
                    end else begin
                        exp_val = q.pop_front();
                        model(exp_val, en, em);
                        check("rnd_rebuilt", 32'(acc), 32'(exp_val));
                        check("rnd_count", 32'(out_count), 32'(en));
                        check("rnd_nibbles", 32'(nibs), 32'(en));
                        check("rnd_mode", 32'(out_mode), 32'(em));
                    end
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                have = 1'b0;
                sent++;
            end
        end
        check("rnd_words_received", 32'(rcvd), 32'd10000);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_done += 10000;
        check("rnd_words_done", 32'(words_done), 32'(exp_done[15:0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
